// File: rtl/axil_fe_pkg.sv
// Shared constants and state types for the AXI4-Lite stream front end.
// Register indices are offsets above the channel range (NUM_CH + offset).
package axil_fe_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int IDX_CTRL_OFS   = 0;
    localparam int IDX_STATUS_OFS = 1;
    localparam int IDX_OUT_OFS    = 2;

    // STATUS: empties at [NUM_CH-1:0], fulls at [2*NUM_CH-1:NUM_CH]
    localparam int STAT_EMPTY_LSB   = 0;
    localparam int STAT_OUT_CNT_LSB = 16;
    localparam int STAT_OUT_CNT_W   = 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; data_o shows the
// head word whenever empty_o is low. DEPTH must be a power of two.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only alongside a pop
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axil_stream_frontend.sv
// AXI4-Lite slave that pushes word writes into per-channel stream FIFOs and
// serves core output words through a pop register. AXIL_FE_SLVERR_EN enables
// SLVERR on unmapped accesses and empty output pops.
module axil_stream_frontend
    import axil_fe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         awvalid_i,
    input  logic                         wvalid_i,
    input  logic                         bready_i,
    input  logic                         arvalid_i,
    input  logic                         rready_i,
    input  logic [ADDR_W-1:0]            awaddr_i,
    input  logic [ADDR_W-1:0]            araddr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [DATA_W/8-1:0]          be_i,
    input  logic [2:0]                   awprot_i,
    input  logic [2:0]                   arprot_i,
    output logic                         awready_o,
    output logic                         wready_o,
    output logic                         arready_o,
    output logic                         bvalid_o,
    output logic                         rvalid_o,
    output logic [1:0]                   bresp_o,
    output logic [1:0]                   rresp_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic [NUM_CH-1:0]            ch_valid_o,
    output logic [NUM_CH*DATA_W-1:0]     ch_data_o,
    output logic [NUM_CH*(DATA_W/8)-1:0] ch_be_o,
    input  logic [NUM_CH-1:0]            ch_ready_i,
    input  logic                         out_valid_i,
    input  logic [DATA_W-1:0]            out_data_i,
    output logic                         out_ready_o
);
    localparam int BE_W       = DATA_W / 8;
    localparam int CH_W       = DATA_W + BE_W;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_CTRL   = NUM_CH + IDX_CTRL_OFS;
    localparam int IDX_STATUS = NUM_CH + IDX_STATUS_OFS;
    localparam int IDX_OUT    = NUM_CH + IDX_OUT_OFS;
`ifdef AXIL_FE_SLVERR_EN
    localparam logic [1:0] ERR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] ERR_RESP = RESP_OKAY;
`endif

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [IDX_W-1:0]  widx, ridx;
    logic [NUM_CH-1:0] wsel, ch_push, ch_full, ch_empty;
    logic              wr_is_ch, target_full, flush;
    logic              out_full, out_empty, out_pop;
    logic [CNT_W-1:0]  out_count;
    logic [DATA_W-1:0] out_rd_data, status_word;
    logic [CNT_W-1:0]  unused_ch_count [NUM_CH];
    logic              unused_bits;

    assign widx        = awaddr_i[IDX_W-1:0];
    assign ridx        = araddr_i[IDX_W-1:0];
    assign wr_is_ch    = |wsel;
    assign target_full = |(wsel & ch_full);
    assign unused_bits = ^{awprot_i, arprot_i, awaddr_i[ADDR_W-1:IDX_W], araddr_i[ADDR_W-1:IDX_W]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CH_W-1:0] rd_word;

            assign wsel[gi] = (int'(widx) == gi);

            sync_fifo #(.DATA_W(CH_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .push_i  (ch_push[gi]),
                .data_i  ({be_i, wdata_i}),
                .pop_i   (ch_valid_o[gi] && ch_ready_i[gi]),
                .flush_i (flush),
                .data_o  (rd_word),
                .full_o  (ch_full[gi]),
                .empty_o (ch_empty[gi]),
                .count_o (unused_ch_count[gi])
            );

            assign ch_valid_o[gi]                = !ch_empty[gi];
            assign ch_data_o[gi*DATA_W +: DATA_W] = rd_word[DATA_W-1:0];
            assign ch_be_o[gi*BE_W +: BE_W]       = rd_word[CH_W-1:DATA_W];
        end
    endgenerate

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_out_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (out_valid_i && out_ready_o),
        .data_i  (out_data_i),
        .pop_i   (out_pop),
        .flush_i (flush),
        .data_o  (out_rd_data),
        .full_o  (out_full),
        .empty_o (out_empty),
        .count_o (out_count)
    );

    assign out_ready_o = !out_full;

    always_comb begin
        status_word = '0;
        status_word[STAT_EMPTY_LSB +: NUM_CH]            = ch_empty;
        status_word[STAT_EMPTY_LSB + NUM_CH +: NUM_CH]   = ch_full;
        status_word[STAT_OUT_CNT_LSB +: STAT_OUT_CNT_W]  = STAT_OUT_CNT_W'(out_count);
    end

    // Write path: stall (ready low) while the addressed channel is full
    always_comb begin
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        ch_push   = '0;
        flush     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid_i && wvalid_i && !(wr_is_ch && target_full)) begin
                    awready_o = 1'b1;
                    wready_o  = 1'b1;
                    w_state_d = W_RESP;
                    bresp_d   = ERR_RESP;
                    if (wr_is_ch) begin
                        ch_push = wsel;
                        bresp_d = RESP_OKAY;
                    end else if (int'(widx) == IDX_CTRL) begin
                        flush   = wdata_i[0];
                        bresp_d = RESP_OKAY;
                    end
                end
            end
            W_RESP: if (bready_i) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path: data is captured at address acceptance and held in R_DATA
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        arready_o = 1'b0;
        out_pop   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid_i) begin
                    arready_o = 1'b1;
                    r_state_d = R_DATA;
                    rdata_d   = '0;
                    rresp_d   = ERR_RESP;
                    if (int'(ridx) == IDX_STATUS) begin
                        rdata_d = status_word;
                        rresp_d = RESP_OKAY;
                    end else if (int'(ridx) == IDX_OUT && !out_empty) begin
                        rdata_d = out_rd_data;
                        rresp_d = RESP_OKAY;
                        out_pop = 1'b1;
                    end
                end
            end
            R_DATA: if (rready_i) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bvalid_o = (w_state_q == W_RESP);
    assign rvalid_o = (r_state_q == R_DATA);
    assign bresp_o  = bresp_q;
    assign rresp_o  = rresp_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_axil_stream_frontend.sv
// Scoreboard bench: drivers push expected responses/words into queues taken
// from a queue-based model; a negedge monitor pops and compares on handshakes.
module tb_axil_stream_frontend;
    localparam int DATA_W = 32, ADDR_W = 32, NUM_CH = 4, DEPTH = 4, IDX_W = 3;
    localparam int IDX_CTRL = NUM_CH, IDX_STATUS = NUM_CH + 1, IDX_OUT = NUM_CH + 2;
`ifdef AXIL_FE_SLVERR_EN
    localparam logic [1:0] EXP_ERR = 2'b10;
`else
    localparam logic [1:0] EXP_ERR = 2'b00;
`endif

    logic clk, rst_i;
    logic awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i;
    logic [ADDR_W-1:0] awaddr_i, araddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [3:0] be_i;
    logic [2:0] awprot_i, arprot_i;
    logic awready_o, wready_o, arready_o, bvalid_o, rvalid_o;
    logic [1:0] bresp_o, rresp_o;
    logic [DATA_W-1:0] rdata_o;
    logic [NUM_CH-1:0] ch_valid_o, ch_ready_i;
    logic [NUM_CH*DATA_W-1:0] ch_data_o;
    logic [NUM_CH*4-1:0] ch_be_o;
    logic out_valid_i, out_ready_o;
    logic [DATA_W-1:0] out_data_i;

    axil_stream_frontend #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
                           .FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .awvalid_i(awvalid_i), .wvalid_i(wvalid_i), .bready_i(bready_i),
        .arvalid_i(arvalid_i), .rready_i(rready_i),
        .awaddr_i(awaddr_i), .araddr_i(araddr_i), .wdata_i(wdata_i), .be_i(be_i),
        .awprot_i(awprot_i), .arprot_i(arprot_i),
        .awready_o(awready_o), .wready_o(wready_o), .arready_o(arready_o),
        .bvalid_o(bvalid_o), .rvalid_o(rvalid_o), .bresp_o(bresp_o), .rresp_o(rresp_o),
        .rdata_o(rdata_o), .ch_valid_o(ch_valid_o), .ch_data_o(ch_data_o), .ch_be_o(ch_be_o),
        .ch_ready_i(ch_ready_i), .out_valid_i(out_valid_i), .out_data_i(out_data_i),
        .out_ready_o(out_ready_o)
    );

    // Reference model: plain queues for each FIFO plus expected responses
    logic [35:0] ch_q [NUM_CH][$];
    logic [31:0] out_q [$];
    logic [1:0]  b_exp [$];
    logic [33:0] r_exp [$];
    int n_vec = 0, n_err = 0;
    bit hold_resp = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no event, expected one", name);
    endtask

    function automatic logic [31:0] status_model();
        logic [31:0] s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s[c]          = (ch_q[c].size() == 0);
            s[NUM_CH + c] = (ch_q[c].size() == DEPTH);
        end
        s[23:16] = 8'(out_q.size());
        return s;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) ch_q[c].delete();
        out_q.delete();
    endtask

    initial begin
        bready_i = 0;
        rready_i = 0;
        forever begin
            @(posedge clk); #1;
            bready_i = hold_resp ? 1'b0 : 1'($urandom_range(0, 1));
            rready_i = hold_resp ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: a handshake seen at negedge completes at the next posedge
    always @(negedge clk) begin
        if (!rst_i) begin
            if (bvalid_o && bready_i) begin
                if (b_exp.size() == 0) fail_now("bresp_unexpected");
                else check("bresp", 64'(bresp_o), 64'(b_exp.pop_front()));
            end
            if (rvalid_o && rready_i) begin
                if (r_exp.size() == 0) fail_now("rdata_unexpected");
                else check("rresp_rdata", 64'({rresp_o, rdata_o}), 64'(r_exp.pop_front()));
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_valid_o[c] && ch_ready_i[c]) begin
                    if (ch_q[c].size() == 0) fail_now($sformatf("ch%0d_unexpected", c));
                    else check($sformatf("ch%0d_word", c),
                               64'({ch_be_o[c*4 +: 4], ch_data_o[c*DATA_W +: DATA_W]}),
                               64'(ch_q[c].pop_front()));
                end
            end
        end
    end

    task automatic axi_write(int idx, logic [31:0] d, logic [3:0] be);
        bit acc = 0;
        logic [1:0] resp;
        @(posedge clk); #1;
        awaddr_i = $urandom();
        awaddr_i[2:0] = idx[2:0];
        wdata_i = d;
        be_i = be;
        awvalid_i = 1;
        wvalid_i = 1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (awready_o) acc = 1;
        end
        if (!acc) begin
            fail_now("aw_accept_timeout");
            awvalid_i = 0;
            wvalid_i = 0;
            return;
        end
        check("wready_with_awready", 64'(wready_o), 64'(1));
        @(posedge clk); #1;
        awvalid_i = 0;
        wvalid_i = 0;
        if (idx < NUM_CH) begin
            ch_q[idx].push_back({be, d});
            resp = 2'b00;
        end else if (idx == IDX_CTRL) begin
            if (d[0]) model_clear();
            resp = 2'b00;
        end else begin
            resp = EXP_ERR;
        end
        b_exp.push_back(resp);
        $display("wr idx=%0d data=%08h be=%h exp_bresp=%0d", idx, d, be, resp);
    endtask

    task automatic axi_read(int idx);
        bit acc = 0;
        logic [31:0] d;
        logic [1:0] resp;
        @(posedge clk); #1;
        if (idx == IDX_STATUS) ch_ready_i = '0;
        araddr_i = $urandom();
        araddr_i[2:0] = idx[2:0];
        arvalid_i = 1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (arready_o) acc = 1;
        end
        if (!acc) begin
            fail_now("ar_accept_timeout");
            arvalid_i = 0;
            return;
        end
        d = '0;
        resp = EXP_ERR;
        if (idx == IDX_STATUS) begin
            d = status_model();
            resp = 2'b00;
        end else if (idx == IDX_OUT && out_q.size() > 0) begin
            d = out_q.pop_front();
            resp = 2'b00;
        end
        r_exp.push_back({resp, d});
        @(posedge clk); #1;
        arvalid_i = 0;
        $display("rd idx=%0d exp_data=%08h exp_rresp=%0d", idx, d, resp);
    endtask

    task automatic push_out(logic [31:0] d);
        bit acc = 0;
        @(posedge clk); #1;
        out_valid_i = 1;
        out_data_i = d;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            if (out_ready_o) acc = 1;
        end
        if (!acc) fail_now("out_ready_timeout");
        @(posedge clk);
        if (acc) out_q.push_back(d);
        #1 out_valid_i = 0;
        $display("core out push data=%08h", d);
    endtask

    task automatic drain();
        bit done = 0;
        @(posedge clk); #1;
        ch_ready_i = '1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = 1;
            for (int c = 0; c < NUM_CH; c++) if (ch_q[c].size() != 0) done = 0;
        end
        if (!done) fail_now("drain_timeout");
        @(negedge clk);
        check("ch_valid_after_drain", 64'(ch_valid_o), 64'(0));
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = (b_exp.size() == 0) && (r_exp.size() == 0) && !bvalid_o && !rvalid_o;
        end
        if (!done) fail_now("resp_idle_timeout");
    endtask

    initial begin
        logic [31:0] d, st_exp;
        int op, idx;
        rst_i = 1;
        {awvalid_i, wvalid_i, arvalid_i, out_valid_i} = '0;
        awaddr_i = '0; araddr_i = '0; wdata_i = '0; be_i = '0;
        awprot_i = '0; arprot_i = '0; out_data_i = '0; ch_ready_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        @(negedge clk);
        check("rst_readies", 64'({awready_o, wready_o, arready_o}), 64'(0));
        check("rst_valids", 64'({bvalid_o, rvalid_o}), 64'(0));
        check("rst_resp_data", 64'({bresp_o, rresp_o, rdata_o}), 64'(0));
        check("rst_ch_valid", 64'(ch_valid_o), 64'(0));
        check("rst_out_ready", 64'(out_ready_o), 64'(1));

        // Single channel word, visible the cycle after accept
        axi_write(0, 32'h9D79B1A3, 4'hF);
        @(negedge clk);
        check("bvalid_next_cycle", 64'(bvalid_o), 64'(1));
        check("ch0_valid", 64'(ch_valid_o[0]), 64'(1));
        check("ch0_data", 64'(ch_data_o[31:0]), 64'h9D79B1A3);
        check("ch0_be", 64'(ch_be_o[3:0]), 64'hF);
        drain();

        // Fifth write to a full channel stalls until the core frees space
        ch_ready_i = '0;
        for (int i = 0; i < 4; i++) axi_write(2, $urandom(), 4'($urandom_range(0, 15)));
        fork
            axi_write(2, 32'h5A5A0005, 4'h3);
            begin
                repeat (6) @(negedge clk);
                check("full_stall_awready", 64'({awready_o, wready_o}), 64'(0));
                @(posedge clk); #1;
                ch_ready_i = 4'b0100;
            end
        join
        drain();

        // Output FIFO: STATUS reads do not pop; third pop read is empty
        ch_ready_i = '0;
        push_out(32'hA38824BB);
        push_out(32'h6AAC9780);
        axi_read(IDX_STATUS);
        axi_read(IDX_STATUS);
        for (int i = 0; i < 3; i++) axi_read(IDX_OUT);
        wait_idle();

        // Flush with channel 1 and output FIFO full
        for (int i = 0; i < 4; i++) axi_write(1, $urandom(), 4'hF);
        for (int i = 0; i < 4; i++) push_out($urandom());
        @(negedge clk);
        check("out_ready_when_full", 64'(out_ready_o), 64'(0));
        axi_write(IDX_CTRL, 32'h1, 4'hF);
        @(negedge clk);
        check("flush_ch_valid", 64'(ch_valid_o), 64'(0));
        check("flush_out_ready", 64'(out_ready_o), 64'(1));
        axi_read(IDX_STATUS);
        wait_idle();

        // Simultaneous write and STATUS read, responses held off
        hold_resp = 1;
        repeat (2) @(posedge clk);
        st_exp = status_model();
        fork
            axi_write(3, 32'hC0FFEE03, 4'hF);
            axi_read(IDX_STATUS);
        join
        awaddr_i[2:0] = 3'd3;
        araddr_i[2:0] = 3'(IDX_STATUS);
        {awvalid_i, wvalid_i, arvalid_i} = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valids", 64'({bvalid_o, rvalid_o}), 64'(2'b11));
            check("hold_no_reaccept", 64'({awready_o, arready_o}), 64'(0));
            check("hold_rdata", 64'(rdata_o), 64'(st_exp));
        end
        @(posedge clk); #1;
        {awvalid_i, wvalid_i, arvalid_i} = '0;
        hold_resp = 0;
        wait_idle();
        drain();

        // Reset during W_RESP aborts the response and empties the FIFOs
        ch_ready_i = '0;
        push_out(32'h12345678);
        hold_resp = 1;
        axi_write(0, 32'hDEAD0000, 4'hF);
        rst_i = 1;
        @(posedge clk);
        model_clear();
        b_exp.delete();
        r_exp.delete();
        @(negedge clk);
        check("rst_mid_bvalid", 64'(bvalid_o), 64'(0));
        check("rst_mid_ch_valid", 64'(ch_valid_o), 64'(0));
        check("rst_mid_out_ready", 64'(out_ready_o), 64'(1));
        @(posedge clk); #1;
        rst_i = 0;
        hold_resp = 0;
        axi_read(IDX_STATUS);
        wait_idle();

        // Randomized mix against the queue model
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            if (op < 5) begin
                idx = $urandom_range(0, 7);
                d = $urandom();
                if (idx == IDX_CTRL && $urandom_range(0, 3) != 0) d[0] = 1'b0;
                @(posedge clk); #1;
                ch_ready_i = 4'($urandom_range(0, 15));
                if (idx < NUM_CH && ch_q[idx].size() == DEPTH) ch_ready_i[idx] = 1'b1;
                axi_write(idx, d, 4'($urandom_range(0, 15)));
            end else if (op < 8) begin
                idx = ($urandom_range(0, 1) == 1) ? IDX_OUT : $urandom_range(0, 7);
                axi_read(idx);
            end else if (out_q.size() < DEPTH) begin
                push_out($urandom());
            end else begin
                @(negedge clk);
                check("rand_out_full", 64'(out_ready_o), 64'(0));
            end
        end
        hold_resp = 0;
        wait_idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
